// File: rtl/music_pkg.sv
// Shared types and constants for the note-ROM music player.
// Song codes index the three externally instantiated note ROMs.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int NUM_NOTES = 31;
  localparam int HP_W      = 20;
  localparam int DUR_W     = 24;
  localparam int ADDR_W    = 5;

  typedef logic [1:0] song_t;

  localparam song_t SONG_1 = 2'd0;
  localparam song_t SONG_2 = 2'd1;
  localparam song_t SONG_3 = 2'd2;

  // Code 3 has no ROM behind it and falls back to the first song.
  function automatic song_t norm_song(input song_t sel);
    return (sel == 2'd3) ? SONG_1 : sel;
  endfunction

endpackage

// File: rtl/music_if.sv
// Control, ROM and audio signals of the music player grouped as one bundle.
// The slave side is the player; the master side is its controller plus ROMs.
interface music_if;
  import music_pkg::*;

  logic                start;
  logic                stop;
  logic [1:0]          song_sel;
  logic                loop;
  logic [ADDR_W-1:0]   rom_addr;
  logic [HP_W-1:0]     rom_dout1;
  logic [HP_W-1:0]     rom_dout2;
  logic [HP_W-1:0]     rom_dout3;
  logic                speaker;
  logic                busy;
  logic                done;

  modport master (
    output start, stop, song_sel, loop, rom_dout1, rom_dout2, rom_dout3,
    input  rom_addr, speaker, busy, done
  );

  modport slave (
    input  start, stop, song_sel, loop, rom_dout1, rom_dout2, rom_dout3,
    output rom_addr, speaker, busy, done
  );

endinterface

// File: rtl/music_tone_gen.sv
// Square-wave generator: toggles the speaker every half_period cycles while enabled.
// A zero half period is a rest; dropping enable clears the counter and silences the output.
module tone_gen
  import music_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            speaker
);

  logic [HP_W-1:0] count;
  logic            wrap;

  assign wrap = (count == half_period - HP_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      speaker <= 1'b0;
    end else if (!enable || half_period == '0) begin
      count   <= '0;
      speaker <= 1'b0;
    end else if (wrap) begin
      count   <= '0;
      speaker <= ~speaker;
    end else begin
      count   <= count + HP_W'(1);
    end
  end

endmodule

// File: rtl/music_player.sv
// Steps through a note ROM, sounding each half-period entry for a fixed duration
// followed by an optional silent gap; supports looping, stop and song selection.
module music_player
  import music_pkg::*;
#(
  parameter int NOTE_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int LAST_ADDR   = 30
) (
  input  logic   clk,
  input  logic   reset_n,
  music_if.slave bus
);

  localparam logic [DUR_W-1:0]  NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit                HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(LAST_ADDR);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  song_t             song;
  logic [HP_W-1:0]   half_period;
  logic [HP_W-1:0]   rom_sel;
  logic [DUR_W-1:0]  dur;
  logic              done_r;
  logic              note_end, gap_end, advance, finish, play_run;

  assign note_end = (state == PLAY) && (dur == NOTE_LAST);
  assign gap_end  = (state == GAP) && (dur == GAP_LAST);
  assign advance  = HAS_GAP ? gap_end : note_end;
  assign finish   = advance && !(addr < END_ADDR) && !bus.loop;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start && !bus.stop) next_state = FETCH;
      FETCH:   next_state = LOAD;
      LOAD:    next_state = PLAY;
      PLAY: begin
        if (note_end) begin
          if (HAS_GAP)     next_state = GAP;
          else if (finish) next_state = IDLE;
          else             next_state = FETCH;
        end
      end
      GAP: begin
        if (gap_end) begin
          if (finish) next_state = IDLE;
          else        next_state = FETCH;
        end
      end
      default: next_state = IDLE;
    endcase
    if (state != IDLE && bus.stop) next_state = IDLE;
  end

  always_comb begin
    rom_sel = bus.rom_dout1;
    case (song)
      SONG_2:  rom_sel = bus.rom_dout2;
      SONG_3:  rom_sel = bus.rom_dout3;
      default: rom_sel = bus.rom_dout1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      addr   <= '0;
      song   <= SONG_1;
      done_r <= 1'b0;
    end else begin
      state  <= next_state;
      done_r <= finish && !bus.stop;
      if (state == IDLE) begin
        if (bus.start && !bus.stop) begin
          addr <= '0;
          song <= norm_song(bus.song_sel);
        end
      end else if (bus.stop) begin
        addr <= '0;
      end else if (advance) begin
        addr <= (addr < END_ADDR) ? addr + ADDR_W'(1) : '0;
      end
    end
  end

  // The duration counter only runs while remaining in a timed state, so
  // FETCH/LOAD and every state change leave it cleared for the next interval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_period <= '0;
      dur         <= '0;
    end else begin
      if (state == LOAD) half_period <= rom_sel;
      if (next_state == state && (state == PLAY || state == GAP))
        dur <= dur + DUR_W'(1);
      else
        dur <= '0;
    end
  end

  // Tone runs only while PLAY continues, so the edge leaving PLAY already silences it.
  assign play_run = (state == PLAY) && (next_state == PLAY);

  tone_gen u_tone_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (play_run),
    .half_period (half_period),
    .speaker     (bus.speaker)
  );

  assign bus.rom_addr = addr;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;

endmodule

// File: tb/tb_music_player.sv
// Randomized self-checking bench for music_player against a note-frame reference model.
module tb_music_player;
  import music_pkg::*;

  localparam int NOTE  = 100;
  localparam int GAPC  = 4;
  localparam int LAST  = 3;
  localparam int FRAME = NOTE + GAPC + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  music_if bus();

  music_player #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAPC), .LAST_ADDR(LAST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [19:0] rom_tab [3][32];

  always @(posedge clk) begin
    bus.rom_dout1 <= rom_tab[0][bus.rom_addr];
    bus.rom_dout2 <= rom_tab[1][bus.rom_addr];
    bus.rom_dout3 <= rom_tab[2][bus.rom_addr];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within a note frame (FETCH, LOAD, NOTE play cycles, gap).
  bit m_active, m_done;
  int m_off, m_addr, m_song;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_off = 0; m_addr = 0; m_song = 0;
  endtask

  task automatic model_step();
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (!m_active) begin
      if (bus.start && !bus.stop) begin
        m_active = 1; m_off = 0; m_addr = 0;
        m_song = (bus.song_sel == 2'd3) ? 0 : int'(bus.song_sel);
      end
    end else if (bus.stop) begin
      m_active = 0; m_addr = 0;
    end else if (m_off == FRAME - 1) begin
      if (m_addr < LAST) begin
        m_addr++; m_off = 0;
      end else if (bus.loop) begin
        m_addr = 0; m_off = 0;
      end else begin
        m_active = 0; m_addr = 0; m_done = 1;
      end
    end else begin
      m_off++;
    end
  endtask

  function automatic int exp_speaker();
    int p, hp;
    if (!m_active || m_off < 2 || m_off > NOTE + 1) return 0;
    p  = m_off - 2;
    hp = int'(rom_tab[m_song][m_addr]);
    if (hp == 0) return 0;
    return (p / hp) % 2;
  endfunction

  int tog [4];
  int busy_cyc, done_cnt, wraps;
  logic prev_spk;
  logic [4:0] prev_addr;

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) tog[i] = 0;
    busy_cyc = 0; done_cnt = 0; wraps = 0;
    prev_spk = bus.speaker; prev_addr = bus.rom_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("busy",     bus.busy,     m_active);
    chk("rom_addr", bus.rom_addr, m_addr);
    chk("done",     bus.done,     m_done);
    chk("speaker",  bus.speaker,  exp_speaker());
    if (bus.speaker !== prev_spk) tog[m_addr]++;
    prev_spk = bus.speaker;
    if (bus.busy) busy_cyc++;
    if (bus.done) done_cnt++;
    if (bus.busy && prev_addr == 5'd3 && bus.rom_addr == 5'd0) wraps++;
    prev_addr = bus.rom_addr;
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    bus.song_sel = sel;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.start = 0; bus.stop = 0; bus.loop = 0; bus.song_sel = 0;
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 32; a++) rom_tab[s][a] = '0;
    rom_tab[0][0] = 20'd5; rom_tab[0][1] = 20'd10;
    rom_tab[0][2] = 20'd0; rom_tab[0][3] = 20'd25;
    for (int s = 1; s < 3; s++)
      for (int a = 0; a < 4; a++) rom_tab[s][a] = 20'($urandom_range(0, 12));
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_busy",    bus.busy,     0);
    chk("rst_speaker", bus.speaker,  0);
    chk("rst_addr",    bus.rom_addr, 0);
    chk("rst_done",    bus.done,     0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Full non-looping play of song 1
    clear_stats();
    pulse_start(2'd0);
    chk("busy_after_start", bus.busy, 1);
    wait_done(1000);
    chk("s1_done",        done_cnt, 1);
    chk("s1_busy_cycles", busy_cyc, 4 * FRAME);
    chk("s1_tog0",        tog[0],   20);
    chk("s1_tog1",        tog[1],   10);
    chk("s1_tog2",        tog[2],   0);
    chk("s1_tog3",        tog[3],   4);
    repeat (5) tick();
    chk("s1_done_once",   done_cnt, 1);

    // Stop part-way through note 1
    clear_stats();
    pulse_start(2'd0);
    repeat (FRAME + 2 + 40) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_busy",    bus.busy,     0);
    chk("stop_speaker", bus.speaker,  0);
    chk("stop_addr",    bus.rom_addr, 0);
    repeat (150) tick();
    chk("stop_no_done", done_cnt, 0);

    // Looping, then loop cleared during the second pass
    clear_stats();
    bus.loop = 1'b1;
    pulse_start(2'd0);
    repeat (4 * FRAME + 10) tick();
    chk("loop_no_done", done_cnt, 0);
    chk("loop_wrap",    wraps,    1);
    bus.loop = 1'b0;
    wait_done(600);
    chk("loop_done",       done_cnt, 1);
    chk("loop_wrap_final", wraps,    1);
    repeat (3) tick();

    // song_sel 3 aliases song 1; later select changes are ignored
    clear_stats();
    pulse_start(2'd3);
    bus.song_sel = 2'd1;
    repeat (30) tick();
    bus.song_sel = 2'd2;
    wait_done(1000);
    chk("sel3_done", done_cnt, 1);
    chk("sel3_tog0", tog[0],   20);
    chk("sel3_tog2", tog[2],   0);
    repeat (3) tick();

    // start with stop, and start while busy
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("startstop_busy", bus.busy, 0);
    clear_stats();
    pulse_start(2'd2);
    repeat (50) tick();
    pulse_start(2'd1);
    repeat (200) tick();
    pulse_start(2'd0);
    wait_done(1000);
    chk("rebusy_done",   done_cnt, 1);
    chk("rebusy_cycles", busy_cyc, 4 * FRAME);
    repeat (3) tick();

    // Randomized control traffic
    for (int i = 0; i < 4000; i++) begin
      bus.start    = ($urandom_range(0, 39) == 0);
      bus.stop     = ($urandom_range(0, 499) == 0);
      bus.song_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bus.loop = ~bus.loop;
      tick();
    end
    bus.start = 0; bus.loop = 0; bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("rand_idle", bus.busy, 0);

    // Asynchronous reset in the middle of a sounding note
    clear_stats();
    pulse_start(2'd0);
    repeat (9) tick();
    chk("pre_reset_spk", bus.speaker, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy",    bus.busy,     0);
    chk("arst_speaker", bus.speaker,  0);
    chk("arst_addr",    bus.rom_addr, 0);
    chk("arst_done",    bus.done,     0);
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (500) tick();
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle",    bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
